// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// opcode constants and the default program-counter width.
package pc_sequencer_pkg;

   localparam int PC_W_DEFAULT = 32;
   localparam int FLUSH_CNT_W  = 3;

   localparam logic [3:0] OPC_BEQ  = 4'd6;
   localparam logic [3:0] OPC_BNE  = 4'd7;
   localparam logic [3:0] OPC_HALT = 4'd15;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones once full.
module pc_sequencer_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Increment only while not yet saturated
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register, clear wins over increment
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner and fetch sequencer: free-runs the PC, redirects on
// taken branches with a fixed-length flush, freezes on stall and parks in
// HALT until restarted.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int          PC_W         = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [3:0]  HALT_OPCODE  = OPC_HALT,
   parameter int          FLUSH_CYCLES = 1,
   parameter int          CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             pc_load_en_i,
   input  logic [PC_W-1:0]  pc_load_val_i,
   input  logic [3:0]       opcode_ex_i,
   input  logic             instr_valid_ex_i,
   input  logic             restart_i,
   output logic [PC_W-1:0]  curr_pc_o,
   output logic             fetch_en_o,
   output logic             flush_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] branch_count_o
);

   // Counter is loaded with FLUSH_CYCLES-1 so flush lasts FLUSH_CYCLES cycles
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   seq_state_e             state_q, state_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic                   branch_inc;
   logic                   halt_hit;

   assign halt_hit = instr_valid_ex_i && (opcode_ex_i == HALT_OPCODE);

   // Next-state and PC selection; HALT beats redirect beats stall in RUN
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      flush_cnt_d = flush_cnt_q;
      branch_inc  = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_hit) begin
               state_d = ST_HALT;
            end else if (pc_load_en_i) begin
               pc_d        = pc_load_val_i;
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_INIT;
               branch_inc  = 1'b1;
            end else if (!stall_i) begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            end
         end
         ST_HALT: begin
            if (restart_i) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State, PC and flush counter registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   pc_sequencer_sat_counter #(
      .CNT_W (CNT_W)
   ) u_branch_cnt (
      .clk_i   (clk_i),
      .clr_i   (rst_i),
      .inc_i   (branch_inc),
      .count_o (branch_count_o)
   );

   assign curr_pc_o  = pc_q;
   assign fetch_en_o = (state_q == ST_RUN) && !stall_i;
   assign flush_o    = (state_q == ST_FLUSH);
   assign halted_o   = (state_q == ST_HALT);

endmodule
